// File: rtl/adder_led_scheduler.sv
// adder_led_scheduler
//   Shares one external 3-bit adder between two requester channels. Each
//   channel offers an operand pair with a valid/ready handshake; a
//   round-robin arbiter picks the winner in IDLE, the operands are latched and
//   presented to the adder, the registered sum is returned to the winner with
//   a one-cycle resp_valid pulse, and a 6-LED thermometer bar shows the result
//   for at least HOLD_CYCLES cycles before the next request can be taken.
//
// Ports
//   clk, rst_n               clock and asynchronous active-low reset
//   req0_valid/a/b, req0_ready   channel 0 request and handshake
//   req1_valid/a/b, req1_ready   channel 1 request and handshake
//   adder_a, adder_b         operands to the shared adder ({1'b0, latched})
//   adder_c                  combinational sum returned by the adder
//   resp_valid, resp_id      one-cycle response pulse and owning channel
//   resp_sum                 registered adder result
//   led                      thermometer bar of the last result
//   busy                     high whenever the scheduler is not idle
//   ovf                      sticky: a sum above 6 was captured
//
// Parameters
//   HOLD_CYCLES  cycles spent in HOLD after each response (1..255)
//   CNT_W        hold counter width, must hold HOLD_CYCLES-1

module adder_led_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  output logic       req1_ready,
  output logic [2:0] adder_a,
  output logic [2:0] adder_b,
  input  logic [3:0] adder_c,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [3:0] resp_sum,
  output logic [5:0] led,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last_grant;
  logic               gnt_id;
  logic [1:0]         op_a;
  logic [1:0]         op_b;
  logic [CNT_W-1:0]   hold_cnt;
  logic               grant_ch;
  logic               handshake;

  // Map a sum onto the LED bar: one lit LED per unit of the sum. Anything
  // above 6 cannot come from legal 2-bit operands, so the bar saturates.
  function automatic logic [5:0] therm(input logic [3:0] s);
    logic [5:0] r;
    if (s > 4'd6) begin
      r = 6'h3f;
    end else begin
      r = 6'((7'd1 << s) - 7'd1);
    end
    return r;
  endfunction

  // Round-robin arbiter. When both channels want service the one that did
  // not win last time gets it; otherwise the lone requester wins. The grant
  // only becomes a handshake while idle, so ready is never high for both.
  always_comb begin
    grant_ch = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_ch = ~last_grant;
    end else if (req1_valid) begin
      grant_ch = 1'b1;
    end
  end

  assign handshake  = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant_ch;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_ch;

  // Next-state decode for the IDLE -> ADD -> RESP -> HOLD sequence. HOLD
  // leaves once the counter loaded in RESP has run down to zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ADD;
      ADD:     state_nxt = RESP;
      RESP:    state_nxt = HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand and result registers. Operands and the grant are taken on
  // the handshake; the adder result, LED bar and overflow flag are captured at
  // the end of ADD so they appear together with the RESP pulse. The LED bar
  // keeps its value until the next capture, and ovf only clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      hold_cnt   <= '0;
      resp_sum   <= '0;
      led        <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (handshake) begin
            op_a       <= grant_ch ? req1_a : req0_a;
            op_b       <= grant_ch ? req1_b : req0_b;
            gnt_id     <= grant_ch;
            last_grant <= grant_ch;
          end
        end
        ADD: begin
          resp_sum <= adder_c;
          led      <= therm(adder_c);
          if (adder_c > 4'd6) begin
            ovf <= 1'b1;
          end
        end
        RESP: begin
          hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign adder_a    = {1'b0, op_a};
  assign adder_b    = {1'b0, op_b};
  assign resp_valid = (state == RESP);
  assign resp_id    = gnt_id;
  assign busy       = (state != IDLE);

endmodule
